// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer family.
// Contents:
//   RR_MODE / FIXED_MODE  - values of the rr_mode select input
//   out_state_e           - occupancy of the one-entry output register
//   wrap_inc()            - index increment that wraps modulo a channel count
package stream_mux_pkg;

    localparam logic FIXED_MODE = 1'b0;
    localparam logic RR_MODE    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Next index after idx, returning to 0 once n is reached.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector starting one past i_last, wrapping, and
// ending at i_last itself; the first requester found is granted.
// Ports:
//   i_req     - NUM_IN-bit request vector
//   i_last    - index of the most recently granted channel
//   o_grant_c - one-hot grant (all zero when nothing requests)
//   o_idx_c   - encoded index of the granted channel (0 when no grant)
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned ADDR_W = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [ADDR_W-1:0] i_last,
    output logic [NUM_IN-1:0] o_grant_c,
    output logic [ADDR_W-1:0] o_idx_c
);

    logic [ADDR_W-1:0] w_pos;
    logic              w_found;

    // Walk NUM_IN positions; the final step lands back on i_last.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        w_found   = 1'b0;
        w_pos     = i_last;
        for (int k = 0; k < NUM_IN; k++) begin
            w_pos = ADDR_W'(wrap_inc(32'(w_pos), NUM_IN));
            if (!w_found && i_req[w_pos]) begin
                w_found          = 1'b1;
                o_grant_c[w_pos] = 1'b1;
                o_idx_c          = w_pos;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream multiplexer with fixed-address and round-robin
// selection, feeding a one-entry output register.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   in_data / in_valid   - NUM_IN producer channels, channel i at [i*WIDTH +: WIDTH]
//   in_ready             - combinational per-channel ready, one-hot or zero
//   address, rr_mode     - fixed-mode select and mode (0 fixed, 1 round-robin)
//   out_data / out_chan  - registered beat and its source channel
//   out_valid, out_ready - consumer handshake
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    rr_mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [ADDR_W-1:0]       out_chan,
    output logic                    out_valid,
    input  logic                    out_ready
);

    out_state_e        r_state;
    logic [WIDTH-1:0]  r_data;
    logic [ADDR_W-1:0] r_chan;
    logic [ADDR_W-1:0] r_last;

    logic [WIDTH-1:0]  w_ch_data [NUM_IN];
    logic [NUM_IN-1:0] w_rr_grant;
    logic [ADDR_W-1:0] w_rr_idx;
    logic [NUM_IN-1:0] w_fix_grant;
    logic              w_addr_ok;
    logic [NUM_IN-1:0] w_grant;
    logic [ADDR_W-1:0] w_gidx;
    logic              w_load_en;
    logic              w_xfer;

    // Unpack the flat input bus into per-channel words.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
        assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NUM_IN (NUM_IN),
        .ADDR_W (ADDR_W)
    ) u_rr_pick (
        .i_req     (in_valid),
        .i_last    (r_last),
        .o_grant_c (w_rr_grant),
        .o_idx_c   (w_rr_idx)
    );

    // Extra bit avoids a constant compare when NUM_IN is a power of two.
    assign w_addr_ok = ({1'b0, address} < (ADDR_W+1)'(NUM_IN));

    // Fixed-address grant: only the addressed channel, and only if valid.
    always_comb begin
        w_fix_grant = '0;
        if (w_addr_ok && in_valid[address]) begin
            w_fix_grant[address] = 1'b1;
        end
    end

    assign w_grant   = (rr_mode == RR_MODE) ? w_rr_grant : w_fix_grant;
    assign w_gidx    = (rr_mode == RR_MODE) ? w_rr_idx   : address;
    assign w_load_en = (r_state == ST_EMPTY) || out_ready;

    // Ready is masked during reset so no handshake is counted in that cycle.
    assign in_ready = (w_load_en && !reset) ? w_grant : '0;
    assign w_xfer   = |in_ready;

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_chan  <= '0;
            r_last  <= ADDR_W'(NUM_IN - 1);
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_state <= ST_FULL;
                r_data  <= w_ch_data[w_gidx];
                r_chan  <= w_gidx;
                if (rr_mode == RR_MODE) begin
                    r_last <= w_gidx;
                end
            end else begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_chan  = r_chan;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus a random
// phase, all checked against a behavioural model of the selection rules.
module tb_stream_mux_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned AW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [AW-1:0]   address;
    logic            rr_mode;
    logic [W-1:0]    out_data;
    logic [AW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;

    logic [6*W-1:0]  in_data6;
    logic [5:0]      in_valid6;
    logic [5:0]      in_ready6;
    logic [2:0]      address6;
    logic            rr_mode6;
    logic [W-1:0]    out_data6;
    logic [2:0]      out_chan6;
    logic            out_valid6;
    logic            out_ready6;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int           m_valid, m_chan, m_last;
    logic [W-1:0] m_data;
    int           x_valid, x_chan, x_last;
    logic [W-1:0] x_data;
    logic [N-1:0] e_ready;

    always #5 clk = ~clk;

    stream_mux_rr #(.NUM_IN(N), .WIDTH(W)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .address(address), .rr_mode(rr_mode),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.NUM_IN(6), .WIDTH(W)) u_dut6 (
        .clk(clk), .reset(reset), .in_data(in_data6), .in_valid(in_valid6),
        .in_ready(in_ready6), .address(address6), .rr_mode(rr_mode6),
        .out_data(out_data6), .out_chan(out_chan6), .out_valid(out_valid6),
        .out_ready(out_ready6)
    );

    // Behavioural model: decide the grant from the rules, then the next state.
    task automatic model_eval();
        int g;
        int c;
        g       = -1;
        e_ready = '0;
        x_valid = m_valid; x_data = m_data; x_chan = m_chan; x_last = m_last;
        if (reset) begin
            x_valid = 0; x_data = '0; x_chan = 0; x_last = N - 1;
        end else if (m_valid == 0 || out_ready) begin
            if (rr_mode) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (g < 0 && in_valid[c[AW-1:0]]) g = c;
                end
            end else if (int'(address) < N && in_valid[address]) begin
                g = int'(address);
            end
            if (g >= 0) begin
                e_ready[g[AW-1:0]] = 1'b1;
                x_valid = 1;
                x_data  = in_data[g*W +: W];
                x_chan  = g;
                if (rr_mode) x_last = g;
            end else begin
                x_valid = 0;
            end
        end
    endtask

    task automatic clock();
        model_eval();
        @(posedge clk);
        m_valid = x_valid; m_data = x_data; m_chan = x_chan; m_last = x_last;
        #1;
    endtask

    task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clock();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 4'hF; rr_mode = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_ready: got %b want 0000", in_ready);
        end
        clock(); clock();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d want 0/00/0", out_valid, out_data, out_chan);
        end
        in_valid = '0;
        reset = 1'b0;
        clock();
    endtask

    task automatic test_fixed();
        rr_mode = 1'b0; address = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        set_data(8'h11, 8'h22, 8'hA5, 8'h44);
        #1;
        n_cmp++;
        if (in_ready !== 4'b0100) begin
            n_err++; $display("FAIL fixed_ready: got %b want 0100", in_ready);
        end
        clock();
        n_cmp++;
        if (out_data !== 8'hA5 || out_chan !== 2'd2 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fixed_load: got d=%h c=%0d v=%b want a5/2/1", out_data, out_chan, out_valid);
        end
        address = 2'd1; in_valid = 4'b1101;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL fixed_invalid_ready: got %b want 0000", in_ready);
        end
        clock();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
            n_err++;
            $display("FAIL fixed_drain: got v=%b d=%h c=%0d want 0/a5/2", out_valid, out_data, out_chan);
        end
        in_valid = '0;
    endtask

    task automatic test_fixed_oob();
        rr_mode6 = 1'b0; out_ready6 = 1'b1; address6 = 3'd0; in_valid6 = 6'b000001;
        in_data6 = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h5A};
        clock();
        n_cmp++;
        if (out_valid6 !== 1'b1 || out_data6 !== 8'h5A) begin
            n_err++; $display("FAIL oob_setup: got v=%b d=%h want 1/5a", out_valid6, out_data6);
        end
        address6 = 3'd5; in_valid6 = 6'b011111;
        #1;
        n_cmp++;
        if (in_ready6 !== 6'b000000) begin
            n_err++; $display("FAIL oob_ch5_invalid_ready: got %b want 000000", in_ready6);
        end
        address6 = 3'd7; in_valid6 = 6'b111111;
        #1;
        n_cmp++;
        if (in_ready6 !== 6'b000000) begin
            n_err++; $display("FAIL oob_addr7_ready: got %b want 000000", in_ready6);
        end
        clock();
        n_cmp++;
        if (out_valid6 !== 1'b0 || out_data6 !== 8'h5A || out_chan6 !== 3'd0) begin
            n_err++;
            $display("FAIL oob_drain: got v=%b d=%h c=%0d want 0/5a/0", out_valid6, out_data6, out_chan6);
        end
        in_valid6 = '0;
    endtask

    task automatic test_rr_all();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        rr_mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            set_data(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            clock();
            n_cmp++;
            if (out_valid !== 1'b1 || int'(out_chan) != exp_seq[i] || out_data !== m_data) begin
                n_err++;
                $display("FAIL rr_all_beat%0d: got v=%b c=%0d d=%h want 1/%0d/%h",
                         i, out_valid, out_chan, out_data, exp_seq[i], m_data);
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [N-1:0] exp_rdy [3] = '{4'b1000, 4'b0010, 4'b1000};
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            set_data(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            #1;
            n_cmp++;
            if (in_ready !== exp_rdy[i]) begin
                n_err++; $display("FAIL rr_sparse_ready%0d: got %b want %b", i, in_ready, exp_rdy[i]);
            end
            clock();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rr_mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        set_data(8'h11, 8'h3C, 8'h77, 8'h99);
        clock(); clock();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_ready%0d: got %b want 0000", i, in_ready);
            end
            clock();
            n_cmp++;
            if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 8'h3C) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b c=%0d d=%h want 1/1/3c", i, out_valid, out_chan, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0100) begin
            n_err++; $display("FAIL bp_release_ready: got %b want 0100", in_ready);
        end
        clock();
        n_cmp++;
        if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 8'h77) begin
            n_err++;
            $display("FAIL bp_release_load: got v=%b c=%0d d=%h want 1/2/77", out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_reset_mid();
        rr_mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        set_data(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        clock();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_mid_ready: got %b want 0000", in_ready);
        end
        clock();
        reset = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_chan !== 2'd0 || out_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got v=%b c=%0d d=%h want 0/0/00", out_valid, out_chan, out_data);
        end
        #1;
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++; $display("FAIL reset_mid_first_grant: got %b want 0001", in_ready);
        end
        clock();
        n_cmp++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'hA1) begin
            n_err++;
            $display("FAIL reset_mid_first_beat: got v=%b c=%0d d=%h want 1/0/a1", out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
            address   = AW'($urandom);
            set_data(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            #1;
            model_eval();
            n_cmp++;
            if (in_ready !== e_ready) begin
                n_err++; $display("FAIL rand_ready@%0d: got %b want %b", i, in_ready, e_ready);
            end
            clock();
            n_cmp++;
            if (out_valid !== 1'(m_valid) || out_chan !== AW'(m_chan) || out_data !== m_data) begin
                n_err++;
                $display("FAIL rand_out@%0d: got v=%b c=%0d d=%h want %0d/%0d/%h",
                         i, out_valid, out_chan, out_data, m_valid, m_chan, m_data);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_valid = '0; address = '0; rr_mode = 1'b0; out_ready = 1'b1;
        in_data6 = '0; in_valid6 = '0; address6 = '0; rr_mode6 = 1'b0; out_ready6 = 1'b1;
        m_valid = 0; m_data = '0; m_chan = 0; m_last = N - 1;
        test_reset();
        test_fixed();
        test_fixed_oob();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised, registered N-to-1 stream multiplexer. It is the successor to the 4:1 gate-level multiplexer: N channels of WIDTH-bit data instead of 4 single bits. Each channel has a valid/ready handshake, and there is a one-entry output register. Two selection modes are supported: fixed-address (classic mux) and round-robin arbitration among valid channels. It sits between multiple producer streams and a single consumer in the datapath.

## Interface
Parameters:
- NUM_IN, 4, number of input channels (≥2)
- WIDTH, 8, data bits per channel
- ADDR_W, $clog2(NUM_IN), width of address and channel tag

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NUM_IN  per-channel valid
- in_ready  out  NUM_IN  per-channel ready (combinational, one-hot or zero)
- address  in  ADDR_W  channel select in fixed mode
- rr_mode  in  1  0 = fixed-address, 1 = round-robin
- out_data  out  WIDTH  registered selected data
- out_chan  out  ADDR_W  registered index of source channel
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts beat

## Operation
- Output register states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- load_en = !out_valid || out_ready. The register can refill in the same cycle it drains.
- Fixed mode:
  - sel = address.
  - Grant only if address < NUM_IN and in_valid[address].
  - Channels other than sel never see in_ready.
- Round-robin mode:
  - Pointer `last` holds the last granted channel.
  - Search order: last+1, last+2, …, wrapping modulo NUM_IN, ending at last.
  - The first channel with in_valid=1 is granted.
- in_ready[i] = load_en && grant[i]. At most one bit is set.
- A transfer on channel i occurs when in_valid[i] && in_ready[i]. On transfer:
  - out_data ← channel i data
  - out_chan ← i
  - out_valid ← 1
- load_en with no grant: out_valid ← 0. out_data and out_chan hold their values.
- FULL with out_ready=0: out_data, out_chan and out_valid are stable, and all in_ready=0.
- `last` updates to the granted index only on an RR-mode transfer. Fixed-mode transfers leave it unchanged.
- Changing rr_mode or address takes effect on the same cycle's grant. There is no pipeline flush, and a beat already in the output register is unaffected.
- A producer may drop in_valid without a handshake. The block does not check protocol.

## Timing
- Reset values:
  - out_valid=0
  - out_data=0
  - out_chan=0
  - last=NUM_IN-1, so channel 0 has first RR priority
  - in_ready=0 during the reset cycle
- Reset mid-transfer discards the held beat. The producer's handshake in that cycle does not count.
- Latency is 1 cycle from input handshake to out_valid.
- Throughput is 1 beat per cycle while out_ready=1.
- in_ready depends combinationally on in_valid, address, rr_mode, out_valid and out_ready.
- out_* are driven only from flops.
- Simultaneous drain and fill: the consumer takes the old beat and the new beat is loaded on the same edge. out_valid stays 1.

## Structure
- Package stream_mux_pkg holds:
  - RR_MODE and FIXED_MODE constants
  - a helper function for the wrap-around index increment
- Sub-module rr_pick is the natural split:
  - inputs: NUM_IN-bit request vector and ADDR_W-bit last pointer
  - outputs: one-hot grant and encoded index
  - purely combinational
  - reusable by future arbiters
- Top level contains:
  - the fixed/RR select
  - the ready generation
  - the output register
  - the `last` pointer register

## Test plan
- Fixed mode, address=2, in_valid=4'b1111, ch2 data=0xA5, out_ready=1:
  - in_ready=4'b0100
  - next cycle out_data=0xA5, out_chan=2, out_valid=1
- Fixed mode, address=1, in_valid=4'b1101, then address=5 with NUM_IN=6 and ch5 invalid:
  - in_ready=0 in both cases
  - out_valid falls to 0 after the drain
- RR mode from reset, all four channels valid continuously, out_ready=1:
  - out_chan sequence is 0,1,2,3,0,1, one beat per cycle
- RR mode, in_valid=4'b1010, last=1:
  - grant ch3, then ch1, then ch3
  - channels 0 and 2 are never granted
- Backpressure: FULL with out_chan=1 and out_data=0x3C, out_ready=0 for 3 cycles while all inputs are valid:
  - outputs hold
  - in_ready=0
  - on the first out_ready=1 cycle, the old beat drains and the next RR channel (2) loads on the same edge
- Reset asserted while FULL and during an input handshake:
  - next cycle out_valid=0, out_chan=0, out_data=0
  - first RR grant after reset is channel 0
